// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter: two-master arbiter in front of a single RAM data port.
// Accepts one request at a time and runs it through IDLE -> XFER -> DONE.
// The bus is driven only in XFER. Completion is a one-cycle ack in DONE.
// Ties go round-robin by default. With FIXED_PRIO=1, M0 always wins a tie.
module ram_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wData,
    input  logic [CTRL_W-1:0] m0_ctrl,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rData,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wData,
    input  logic [CTRL_W-1:0] m1_ctrl,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rData,

    output logic              busWe,
    output logic [ADDR_W-1:0] busAddr,
    output logic [DATA_W-1:0] busWData,
    output logic [CTRL_W-1:0] ramControl,
    input  logic [DATA_W-1:0] busRData,

    output logic              owner,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             nextState;
    logic              lastGrant;
    logic              ownerQ;
    logic              winner;
    logic              anyReq;
    logic              latWe;
    logic [ADDR_W-1:0] latAddr;
    logic [DATA_W-1:0] latWData;
    logic [CTRL_W-1:0] latCtrl;
    logic [DATA_W-1:0] rDataQ;

    // Winner selection: a single requester wins. A tie goes to M0 or to the master that was not granted last.
    always_comb begin
        anyReq = m0_req | m1_req;
        winner = 1'b0;
        if (m0_req && m1_req) begin
            winner = FIXED_PRIO ? 1'b0 : ~lastGrant;
        end else if (m1_req) begin
            winner = 1'b1;
        end
    end

    // Next-state logic: advance one state per clock and start only from IDLE with a pending request.
    always_comb begin
        // NOTE: assigning a default before the case means no path can leave nextState unassigned, so no latch is inferred.
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = XFER;
            XFER:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register and transfer datapath: latch the winner in IDLE, capture the read in XFER, record the grant in DONE.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the latched request and read data are also reset, so nothing undefined is visible after reset. The outputs are gated by state anyway.
        if (!reset) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            ownerQ    <= 1'b0;
            latWe     <= 1'b0;
            latAddr   <= '0;
            latWData  <= '0;
            latCtrl   <= '0;
            rDataQ    <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register here update from pre-edge values, independent of statement order.
            state <= nextState;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        ownerQ   <= winner;
                        latWe    <= winner ? m1_we    : m0_we;
                        latAddr  <= winner ? m1_addr  : m0_addr;
                        latWData <= winner ? m1_wData : m0_wData;
                        latCtrl  <= winner ? m1_ctrl  : m0_ctrl;
                    end
                end
                XFER: begin
                    rDataQ <= latWe ? '0 : busRData;
                end
                DONE: begin
                    lastGrant <= ownerQ;
                end
                default: ;
            endcase
        end
    end

    // Output decode: the bus is live only in XFER, and the owner's ack and read data are live only in DONE.
    always_comb begin
        busWe      = 1'b0;
        busAddr    = '0;
        busWData   = '0;
        ramControl = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        m0_rData   = '0;
        m1_rData   = '0;
        if (state == XFER) begin
            busWe      = latWe;
            busAddr    = latAddr;
            busWData   = latWData;
            ramControl = latCtrl;
        end
        if (state == DONE) begin
            if (ownerQ) begin
                m1_ack   = 1'b1;
                m1_rData = rDataQ;
            end else begin
                m0_ack   = 1'b1;
                m0_rData = rDataQ;
            end
        end
    end

    assign owner = ownerQ;
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb_ram_bus_arbiter: directed bench for ram_bus_arbiter.
// One round-robin instance is connected to a byte-lane RAM model.
// A FIXED_PRIO instance shares the master inputs and is used for the tie test.
`timescale 1ns/1ps
module tb_ram_bus_arbiter;

    localparam logic [2:0] CTRL_BYTE = 3'b000;
    localparam logic [2:0] CTRL_WORD = 3'b010;

    logic        clk = 1'b0;
    logic        reset;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wData, m1_addr, m1_wData;
    logic [2:0]  m0_ctrl, m1_ctrl;

    logic        m0_ack, m1_ack, busWe, owner, busy;
    logic [31:0] m0_rData, m1_rData, busAddr, busWData, busRData;
    logic [2:0]  ramControl;

    logic        fpM0Ack, fpM1Ack, fpBusWe, fpOwner, fpBusy;
    logic [31:0] fpM0RData, fpM1RData, fpBusAddr, fpBusWData, fpBusRData;
    logic [2:0]  fpRamControl;

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_bus_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wData(m0_wData),
        .m0_ctrl(m0_ctrl), .m0_ack(m0_ack), .m0_rData(m0_rData),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wData(m1_wData),
        .m1_ctrl(m1_ctrl), .m1_ack(m1_ack), .m1_rData(m1_rData),
        .busWe(busWe), .busAddr(busAddr), .busWData(busWData),
        .ramControl(ramControl), .busRData(busRData),
        .owner(owner), .busy(busy)
    );

    ram_bus_arbiter #(.FIXED_PRIO(1'b1)) dutFp (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wData(m0_wData),
        .m0_ctrl(m0_ctrl), .m0_ack(fpM0Ack), .m0_rData(fpM0RData),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wData(m1_wData),
        .m1_ctrl(m1_ctrl), .m1_ack(fpM1Ack), .m1_rData(fpM1RData),
        .busWe(fpBusWe), .busAddr(fpBusAddr), .busWData(fpBusWData),
        .ramControl(fpRamControl), .busRData(fpBusRData),
        .owner(fpOwner), .busy(fpBusy)
    );

    assign fpBusRData = 32'h0;

    // RAM model: combinational read, with the write committed on the clock edge that closes XFER.
    assign busRData = mem[busAddr[7:2]];
    always @(posedge clk) begin
        if (busWe) begin
            case (ramControl)
                CTRL_BYTE: mem[busAddr[7:2]][busAddr[1:0]*8 +: 8] <= busWData[7:0];
                3'b001:    mem[busAddr[7:2]][busAddr[1]*16 +: 16] <= busWData[15:0];
                default:   mem[busAddr[7:2]] <= busWData;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wData = '0; m0_ctrl = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wData = '0; m1_ctrl = '0;
    endtask

    // Single access from an idle arbiter. Checks the ack latency, then leaves the DUT back in IDLE.
    task automatic access(input bit m, input logic we, input logic [31:0] addr,
                          input logic [31:0] data, input logic [2:0] ctrl,
                          output logic [31:0] rd);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        rd   = 'x;
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wData = data; m1_ctrl = ctrl;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wData = data; m0_ctrl = ctrl;
        end
        while (!seen && n < 10) begin
            step();
            n++;
            if (m ? m1_ack : m0_ack) begin
                seen = 1'b1;
                rd   = m ? m1_rData : m0_rData;
                check($sformatf("other_ack_m%0d", m), 32'(m ? m0_ack : m1_ack), 32'd0);
            end
        end
        quiet();
        check($sformatf("ack_latency_m%0d", m), n, 32'd2);
        step();
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  rrSeq, fpSeq;
        int          rrCnt, fpCnt, bothAck, ackCnt;

        // Reset state
        reset = 1'b0;
        quiet();
        step();
        step();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_bus",   busAddr | busWData | 32'(busWe) | 32'(ramControl), 32'd0);
        check("rst_acks",  m0_rData | m1_rData | 32'(m0_ack) | 32'(m1_ack), 32'd0);
        check("rst_fp",    fpM0RData | fpM1RData | fpBusAddr | fpBusWData | 32'(fpRamControl)
                           | 32'({fpM0Ack, fpM1Ack, fpBusWe, fpOwner, fpBusy}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // 1. M0 word store; later address and data changes must be ignored
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wData = 32'hDEADBEEF; m0_ctrl = CTRL_WORD;
        step();
        check("t1_xfer_we",    32'(busWe), 32'd1);
        check("t1_xfer_addr",  busAddr, 32'h10);
        check("t1_xfer_wdata", busWData, 32'hDEADBEEF);
        check("t1_xfer_ctrl",  32'(ramControl), 32'(CTRL_WORD));
        check("t1_xfer_busy",  32'(busy), 32'd1);
        check("t1_xfer_ack",   32'(m0_ack), 32'd0);
        m0_addr = 32'h99; m0_wData = 32'h0;
        step();
        check("t1_done_we",    32'(busWe), 32'd0);
        check("t1_done_addr",  busAddr, 32'h0);
        check("t1_done_ack",   32'(m0_ack), 32'd1);
        check("t1_done_rdata", m0_rData, 32'h0);
        check("t1_done_m1ack", 32'(m1_ack), 32'd0);
        quiet();
        step();
        check("t1_idle_ack",   32'(m0_ack), 32'd0);
        check("t1_idle_busy",  32'(busy), 32'd0);

        // 2. M0 load returns the stored word
        access(1'b0, 1'b0, 32'h10, 32'h0, CTRL_WORD, rd);
        check("t2_load", rd, 32'hDEADBEEF);

        // 3. Both masters held for 12 cycles after reset: round-robin alternates, fixed-priority serves M0 only
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m0_req = 1'b1; m0_addr = 32'h10; m0_ctrl = CTRL_WORD;
        m1_req = 1'b1; m1_addr = 32'h10; m1_ctrl = CTRL_WORD;
        rrSeq = '0; fpSeq = '0; rrCnt = 0; fpCnt = 0; bothAck = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if ((m0_ack && m1_ack) || (fpM0Ack && fpM1Ack)) bothAck++;
            if ((m0_ack || m1_ack) && rrCnt < 8) begin
                rrSeq[rrCnt] = m1_ack;
                rrCnt++;
            end
            if ((fpM0Ack || fpM1Ack) && fpCnt < 8) begin
                fpSeq[fpCnt] = fpM1Ack;
                fpCnt++;
            end
        end
        quiet();
        check("t3_rr_grants", rrCnt, 32'd4);
        check("t3_rr_seq",    32'(rrSeq), 32'h0000000A);
        check("t3_fp_grants", fpCnt, 32'd4);
        check("t3_fp_seq",    32'(fpSeq), 32'h0);
        check("t3_both_acks", bothAck, 32'd0);
        check("t3_end_idle",  32'(busy), 32'd0);

        // 4. Word preload, then an M1 byte store to 0x21, then an M0 word readback
        access(1'b0, 1'b1, 32'h20, 32'h11223344, CTRL_WORD, rd);
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h21; m1_wData = 32'h000000AB; m1_ctrl = CTRL_BYTE;
        step();
        check("t4_xfer_ctrl",  32'(ramControl), 32'(CTRL_BYTE));
        check("t4_xfer_addr",  busAddr, 32'h21);
        check("t4_xfer_owner", 32'(owner), 32'd1);
        check("t4_xfer_we",    32'(busWe), 32'd1);
        step();
        check("t4_done_ack",   32'(m1_ack), 32'd1);
        check("t4_done_rdata", m1_rData, 32'h0);
        quiet();
        step();
        access(1'b0, 1'b0, 32'h20, 32'h0, CTRL_WORD, rd);
        check("t4_readback", rd, 32'h1122AB44);

        // 5. Reset asserted during the XFER of a store
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h30; m0_wData = 32'h55; m0_ctrl = CTRL_WORD;
        step();
        check("t5_xfer_we", 32'(busWe), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("t5_async_we",   32'(busWe), 32'd0);
        check("t5_async_busy", 32'(busy), 32'd0);
        check("t5_async_addr", busAddr, 32'h0);
        step();
        check("t5_rst_ack_a", 32'(m0_ack | m1_ack), 32'd0);
        step();
        check("t5_rst_ack_b", 32'(m0_ack | m1_ack), 32'd0);
        quiet();
        @(negedge clk);
        reset = 1'b1;
        step();
        check("t5_post_busy",  32'(busy), 32'd0);
        check("t5_post_owner", 32'(owner), 32'd0);
        check("t5_post_bus",   busAddr | busWData | 32'(busWe) | 32'(ramControl), 32'd0);
        check("t5_post_acks",  m0_rData | m1_rData | 32'(m0_ack) | 32'(m1_ack), 32'd0);

        // 6. M1 drops its request right after being latched
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h10; m1_ctrl = CTRL_WORD;
        step();
        check("t6_latched_owner", 32'(owner), 32'd1);
        check("t6_latched_busy",  32'(busy), 32'd1);
        quiet();
        ackCnt = 0;
        rd     = 'x;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m1_ack) begin
                ackCnt++;
                rd = m1_rData;
            end
        end
        check("t6_ack_count", ackCnt, 32'd1);
        check("t6_rdata",     rd, 32'hDEADBEEF);
        check("t6_end_busy",  32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
